// File: rtl/face_det_pkg.sv
// Shared constants and state encoding for the face-detection front end.
// The integral image builder and its RAM size themselves from these values.
package face_det_pkg;

  localparam int IMG_W   = 20;
  localparam int IMG_H   = 20;
  localparam int NUM_PIX = IMG_W * IMG_H;
  localparam int ADDR_W  = 9;
  localparam int PIX_W   = 8;
  localparam int II_W    = 17;
  localparam int X_W     = $clog2(IMG_W);
  localparam int Y_W     = $clog2(IMG_H);

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } ii_state_t;

endpackage

// File: rtl/ii_ram.sv
// Simple dual-port RAM holding the integral image: one write port and one
// registered read port, no reset so it maps onto block RAM.
module ii_ram
  import face_det_pkg::*;
(
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [II_W-1:0]   wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [II_W-1:0]   rd_data
);

  logic [II_W-1:0] mem [NUM_PIX];
  logic [II_W-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Out-of-range read addresses give don't-care data; the builder masks them.
  always_ff @(posedge clk) begin
    rd_data_q <= mem[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/integral_image_builder.sv
// Streams the scaled 20x20 image in raster order and builds its summed-area
// table, keeping a running row sum and the previous row's results in registers.
module integral_image_builder
  import face_det_pkg::*;
(
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              START,
  output logic              SRC_RD,
  output logic [ADDR_W-1:0] SRC_ADDR,
  input  logic [PIX_W-1:0]  SRC_DATA,
  input  logic [ADDR_W-1:0] II_RD_ADDR,
  output logic [II_W-1:0]   II_RD_DATA,
  output logic              BUSY,
  output logic              DONE,
  output logic              VALID
);

  ii_state_t         state_q, state_d;
  logic [ADDR_W-1:0] src_addr_q, src_addr_d;
  logic              src_rd_q, src_rd_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              valid_q, valid_d;
  logic [X_W-1:0]    x_q, x_d;
  logic [Y_W-1:0]    y_q, y_d;
  logic [II_W-1:0]   row_sum_q, row_sum_d;
  logic              rd_ok_q, rd_ok_d;
  logic [II_W-1:0]   prev_row_q [IMG_W];
  logic [II_W-1:0]   prev_row_d [IMG_W];

  logic [II_W-1:0]   pix;
  logic [II_W-1:0]   row_sum_n;
  logic [II_W-1:0]   ii_val;
  logic              wr_en;
  logic [II_W-1:0]   ram_rd_data;

  assign pix       = {{(II_W-PIX_W){1'b0}}, SRC_DATA};
  assign row_sum_n = ((x_q == '0) ? '0 : row_sum_q) + pix;
  assign ii_val    = row_sum_n + ((y_q == '0) ? '0 : prev_row_q[x_q]);
  assign wr_en     = (state_q == FETCH);

  always_comb begin
    state_d    = state_q;
    src_addr_d = src_addr_q;
    src_rd_d   = src_rd_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    valid_d    = valid_q;
    x_d        = x_q;
    y_d        = y_q;
    row_sum_d  = row_sum_q;
    case (state_q)
      IDLE: begin
        if (START) begin
          state_d    = FETCH;
          src_addr_d = '0;
          src_rd_d   = 1'b1;
          busy_d     = 1'b1;
          valid_d    = 1'b0;
          x_d        = '0;
          y_d        = '0;
        end
      end
      FETCH: begin
        row_sum_d = row_sum_n;
        if (src_addr_q == ADDR_W'(NUM_PIX - 1)) begin
          state_d    = IDLE;
          src_addr_d = '0;
          src_rd_d   = 1'b0;
          busy_d     = 1'b0;
          done_d     = 1'b1;
          valid_d    = 1'b1;
          x_d        = '0;
          y_d        = '0;
        end else begin
          src_addr_d = src_addr_q + ADDR_W'(1);
          if (x_q == X_W'(IMG_W - 1)) begin
            x_d = '0;
            y_d = y_q + Y_W'(1);
          end else begin
            x_d = x_q + X_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Reads are only honoured once a complete image is stable in the RAM.
  assign rd_ok_d = valid_q && (II_RD_ADDR < ADDR_W'(NUM_PIX));

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= IDLE;
      src_addr_q <= '0;
      src_rd_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      valid_q    <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      row_sum_q  <= '0;
      rd_ok_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      src_addr_q <= src_addr_d;
      src_rd_q   <= src_rd_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      valid_q    <= valid_d;
      x_q        <= x_d;
      y_q        <= y_d;
      row_sum_q  <= row_sum_d;
      rd_ok_q    <= rd_ok_d;
    end
  end

  // Each column keeps the ii value of the row above for the next row's add.
  for (genvar gi = 0; gi < IMG_W; gi++) begin : g_prev_row
    assign prev_row_d[gi] = (wr_en && (x_q == X_W'(gi))) ? ii_val : prev_row_q[gi];

    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        prev_row_q[gi] <= '0;
      end else begin
        prev_row_q[gi] <= prev_row_d[gi];
      end
    end
  end

  ii_ram u_ii_ram (
    .clk     (CLK),
    .wr_en   (wr_en),
    .wr_addr (src_addr_q),
    .wr_data (ii_val),
    .rd_addr (II_RD_ADDR),
    .rd_data (ram_rd_data)
  );

  assign II_RD_DATA = rd_ok_q ? ram_rd_data : '0;
  assign SRC_RD     = src_rd_q;
  assign SRC_ADDR   = src_addr_q;
  assign BUSY       = busy_q;
  assign DONE       = done_q;
  assign VALID      = valid_q;

endmodule

// File: tb/tb_integral_image_builder.sv
// Scoreboard bench for integral_image_builder: stimulus queues expectations,
// a monitor process compares read data, status and build latency.
module tb_integral_image_builder;
  import face_det_pkg::*;

  logic              CLK = 1'b0;
  logic              RST_N;
  logic              START;
  logic              SRC_RD;
  logic [ADDR_W-1:0] SRC_ADDR;
  logic [PIX_W-1:0]  SRC_DATA;
  logic [ADDR_W-1:0] II_RD_ADDR;
  logic [II_W-1:0]   II_RD_DATA;
  logic              BUSY;
  logic              DONE;
  logic              VALID;

  always #5 CLK = ~CLK;

  logic [PIX_W-1:0] src_mem [NUM_PIX];
  assign SRC_DATA = (SRC_ADDR < ADDR_W'(NUM_PIX)) ? src_mem[SRC_ADDR] : '0;

  integral_image_builder dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .START      (START),
    .SRC_RD     (SRC_RD),
    .SRC_ADDR   (SRC_ADDR),
    .SRC_DATA   (SRC_DATA),
    .II_RD_ADDR (II_RD_ADDR),
    .II_RD_DATA (II_RD_DATA),
    .BUSY       (BUSY),
    .DONE       (DONE),
    .VALID      (VALID)
  );

  // kind 0: read data, kind 1: {SRC_RD,BUSY,DONE,VALID,SRC_ADDR}, kind 2: outstanding builds
  typedef struct {
    int          kind;
    logic [31:0] exp;
    string       name;
  } item_t;

  item_t sb_q[$];
  int    done_exp_q[$];
  logic  chk_req = 1'b0;
  logic  launch  = 1'b0;
  int    checks  = 0;
  int    errors  = 0;

  // Reference: ii(x,y) as a plain double sum over the source image.
  function automatic logic [31:0] model_ii(int a);
    logic [31:0] s;
    int x;
    int y;
    s = 0;
    x = a % IMG_W;
    y = a / IMG_W;
    for (int j = 0; j <= y; j++)
      for (int i = 0; i <= x; i++)
        s += 32'(src_mem[j*IMG_W + i]);
    return s;
  endfunction

  initial begin : monitor
    int          cnt;
    bit          counting;
    bit          st;
    bit          pend;
    int          e;
    item_t       it;
    logic [31:0] act;
    cnt = 0;
    counting = 0;
    forever begin
      @(posedge CLK);
      st   = START && launch && RST_N;
      pend = chk_req;
      if (counting) cnt++;
      if (st) begin
        cnt = 0;
        counting = 1;
      end
      @(negedge CLK);
      if (!RST_N) begin
        counting = 0;
        done_exp_q.delete();
      end
      if (DONE) begin
        checks++;
        if (done_exp_q.size() == 0) begin
          errors++;
          $display("FAIL done_unexpected: DONE pulsed with no build outstanding (count %0d)", cnt);
        end else begin
          e = done_exp_q.pop_front();
          if (!counting || cnt != e) begin
            errors++;
            $display("FAIL done_latency: got %0d cycles, expected %0d", cnt, e);
          end else begin
            $display("ok   done_latency: %0d cycles", cnt);
          end
        end
        counting = 0;
      end
      if (pend) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL sb_empty: output sampled with no expectation queued");
        end else begin
          it = sb_q.pop_front();
          case (it.kind)
            0:       act = 32'(II_RD_DATA);
            1:       act = 32'({SRC_RD, BUSY, DONE, VALID, SRC_ADDR});
            default: act = 32'(done_exp_q.size());
          endcase
          if (act !== it.exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", it.name, act, it.exp);
          end else begin
            $display("ok   %s: %0d", it.name, act);
          end
        end
      end
    end
  end

  task automatic req(input int kind, input int addr, input logic [31:0] exp, input string name);
    item_t it;
    it.kind = kind;
    it.exp  = exp;
    it.name = name;
    if (kind == 0) II_RD_ADDR = ADDR_W'(addr);
    sb_q.push_back(it);
    chk_req = 1'b1;
    @(posedge CLK);
    #1;
    chk_req = 1'b0;
  endtask

  task automatic rd_model(input int addr, input string name);
    req(0, addr, (addr < NUM_PIX) ? model_ii(addr) : 32'd0, name);
  endtask

  task automatic rand_reads(input int n);
    for (int i = 0; i < n; i++) rd_model($urandom_range(0, NUM_PIX - 1), "rd_rand");
  endtask

  task automatic launch_build(input bit with_status);
    START  = 1'b1;
    launch = 1'b1;
    done_exp_q.push_back(NUM_PIX);
    if (with_status) req(1, 0, 32'({4'b1100, 9'd0}), "start_status");
    else begin
      @(posedge CLK);
      #1;
    end
    START  = 1'b0;
    launch = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 1000; i++) begin
      @(posedge CLK);
      #1;
      if (DONE) break;
    end
  endtask

  initial begin : stimulus
    RST_N = 1'b0;
    START = 1'b0;
    II_RD_ADDR = '0;
    for (int i = 0; i < NUM_PIX; i++) src_mem[i] = '0;
    repeat (3) @(posedge CLK);
    #1;
    req(1, 0, 0, "reset_status");
    RST_N = 1'b1;
    req(0, 399, 0, "rd_before_build");
    req(1, 0, 0, "idle_status");

    for (int i = 0; i < NUM_PIX; i++) src_mem[i] = 8'd1;
    launch_build(0);
    wait_done();
    req(0, 399, 400, "ones_399");
    req(0, 19, 20, "ones_19");
    req(0, 20, 2, "ones_20");
    rand_reads(6);

    for (int i = 0; i < NUM_PIX; i++) src_mem[i] = 8'd255;
    launch_build(0);
    wait_done();
    req(0, 399, 102000, "max_399");
    req(0, 0, 255, "max_0");
    req(0, 21, 1020, "max_21");
    rand_reads(4);

    for (int i = 0; i < NUM_PIX; i++) src_mem[i] = '0;
    src_mem[105] = 8'd10;
    launch_build(0);
    wait_done();
    req(0, 105, 10, "spot_105");
    req(0, 104, 0, "spot_104");
    req(0, 85, 0, "spot_85");
    rand_reads(6);

    for (int i = 0; i < NUM_PIX; i++) src_mem[i] = PIX_W'($urandom_range(0, 255));
    launch_build(0);
    repeat (99) @(posedge CLK);
    #1;
    START = 1'b1;
    @(posedge CLK);
    #1;
    START = 1'b0;
    req(0, $urandom_range(0, NUM_PIX - 1), 0, "rd_busy");
    wait_done();
    rand_reads(6);
    req(0, 450, 0, "rd_oob_450");
    req(0, 511, 0, "rd_oob_511");
    launch_build(1);
    wait_done();
    rand_reads(4);

    for (int i = 0; i < NUM_PIX; i++) src_mem[i] = PIX_W'($urandom_range(0, 255));
    launch_build(0);
    repeat (199) @(posedge CLK);
    #1;
    RST_N = 1'b0;
    req(1, 0, 0, "rst_status");
    req(0, 399, 0, "rd_in_reset");
    RST_N = 1'b1;
    req(0, 399, 0, "rd_after_reset");
    for (int i = 0; i < NUM_PIX; i++) src_mem[i] = PIX_W'(i % 256);
    launch_build(0);
    wait_done();
    rd_model(399, "ramp_399");
    rd_model(255, "ramp_255");
    rand_reads(4);

    req(2, 0, 0, "builds_outstanding");
    repeat (2) @(posedge CLK);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
